alu32_share_ctrl: RTL

//   Sequencer/arbiter that shares one gate-level 32-bit ALU between two requesters.

---
 rtl/alu32_share_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu32_share_ctrl.sv
// alu32_share_ctrl: shares a single combinational ALU between two requesters.
// One operation is in flight at a time. Operands are latched on accept, Enable is
// held for ALU_LAT cycles while the datapath settles, and the result is then
// captured and returned tagged with the requester that issued it.
module alu32_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Settle counter reload value; counts down to zero, capture happens at zero.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_last_grant;
  logic             r_alu_enable;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic [OPW-1:0]   r_alu_op;

  logic w_idle;
  logic w_grant_id;
  logic w_take0;
  logic w_take1;
  logic w_accept;
  logic w_capture;
  logic w_release;

  // Round-robin arbitration on the current-cycle valids; a tie goes to the
  // requester that was not granted last time.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = req1_valid;
    end
    w_take0   = w_idle && req0_valid && !w_grant_id;
    w_take1   = w_idle && req1_valid &&  w_grant_id;
    w_accept  = w_take0 || w_take1;
    w_capture = (r_state == S_BUSY) && (r_cnt == 4'd0);
    w_release = (r_state == S_DONE) && rsp_ready;
  end

  // Sequencer: IDLE -> BUSY on accept, BUSY -> DONE after the settle window,
  // DONE -> IDLE once the consumer takes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_alu_enable <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_cnt        <= LAT_M1;
            r_alu_enable <= 1'b1;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_capture) begin
            r_alu_enable <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (w_release) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_alu_enable <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Operand/opcode latch and response tag; values persist after the operation
  // so the ALU inputs do not toggle between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_alu_op  <= '0;
      r_rsp_id  <= 1'b0;
    end else if (w_accept) begin
      r_alu_in1 <= w_grant_id ? req1_a  : req0_a;
      r_alu_in2 <= w_grant_id ? req1_b  : req0_b;
      r_alu_op  <= w_grant_id ? req1_op : req0_op;
      r_rsp_id  <= w_grant_id;
    end
  end

  // Result capture at the end of the settle window; held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
    end else if (w_capture) begin
      r_rsp_result <= alu_out;
    end
  end

  assign req0_ready = w_take0;
  assign req1_ready = w_take1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_op     = r_alu_op;
  assign alu_enable = r_alu_enable;

endmodule
